// File: rtl/inc_pulse_pkg.sv
// Shared types and defaults for the inc_pulse_gen push-button conditioner.
// Optional auto-repeat is selected with the INC_AUTO_REPEAT_EN macro in the top.
package inc_pulse_pkg;

    // Conditioner FSM states, 3-bit encoding
    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        DEB_PRESS   = 3'd1,
        HOLD_DELAY  = 3'd2,
        HOLD_REPEAT = 3'd3,
        DEB_RELEASE = 3'd4
    } inc_state_e;

    // Default timing constants (clk cycles)
    localparam int DEF_DEB_CYCLES   = 16;
    localparam int DEF_REPEAT_DELAY = 64;
    localparam int DEF_REPEAT_RATE  = 16;
    localparam int DEF_CNT_W        = 8;

    // True when every timing value is at least 2 and fits in a w-bit timer
    function automatic bit cfg_ok(input int deb, input int dly, input int rate, input int w);
        longint cap;
        cap = (longint'(1) << w) - 1;
        return (deb >= 2) && (dly >= 2) && (rate >= 2) &&
               (longint'(deb) <= cap) && (longint'(dly) <= cap) && (longint'(rate) <= cap);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for raw asynchronous pins (button, up_down_sel, ...).
// Both stages clear asynchronously on reset.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    // Two back-to-back flops; the first may go metastable, the second resolves it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/inc_pulse_gen.sv
// Push-button conditioner: synchronises and debounces btn_in, emits one-cycle
// registered inc pulses and exports the debounced level.
// Macro INC_AUTO_REPEAT_EN enables hold-to-repeat (HOLD_REPEAT state, repeating
// output); without it a press yields exactly one inc and repeating is tied 0.
module inc_pulse_gen
    import inc_pulse_pkg::*;
#(
    parameter int DEB_CYCLES   = DEF_DEB_CYCLES,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic inc,
    output logic btn_level,
    output logic repeating
);

    // Illegal timing configurations are rejected at elaboration
    if (!cfg_ok(DEB_CYCLES, REPEAT_DELAY, REPEAT_RATE, CNT_W)) begin : g_bad_cfg
        $error("inc_pulse_gen: timing parameters must be >= 2 and fit in CNT_W bits");
    end

    // Terminal timer values: a phase of N cycles ends when tmr reaches N-1
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
`ifdef INC_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(REPEAT_RATE - 1);
`endif

    logic             sync;
    inc_state_e       state;
    inc_state_e       state_nxt;
    logic [CNT_W-1:0] tmr;
    logic             tmr_reload;
    logic             inc_nxt;

    sync_2ff #(.W(1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_in),
        .q     (sync)
    );

    // State register and registered inc pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            inc   <= 1'b0;
        end else begin
            state <= state_nxt;
            inc   <= inc_nxt;
        end
    end

    // Shared timer: zero on any state change or repeat reload, else saturating count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmr <= '0;
        end else if ((state_nxt != state) || tmr_reload) begin
            tmr <= '0;
        end else if (tmr != '1) begin
            tmr <= tmr + CNT_W'(1);
        end
    end

    // Next-state and pulse decode; a sync change always outranks a timer terminal
    always_comb begin
        state_nxt  = state;
        tmr_reload = 1'b0;
        inc_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (sync) state_nxt = DEB_PRESS;
            end
            DEB_PRESS: begin
                if (!sync) begin
                    state_nxt = IDLE;
                end else if (tmr == DEB_LAST) begin
                    state_nxt = HOLD_DELAY;
                    inc_nxt   = 1'b1;
                end
            end
            HOLD_DELAY: begin
                if (!sync) begin
                    state_nxt = DEB_RELEASE;
                end
`ifdef INC_AUTO_REPEAT_EN
                else if (tmr == DLY_LAST) begin
                    state_nxt = HOLD_REPEAT;
                    inc_nxt   = 1'b1;
                end
`endif
            end
            HOLD_REPEAT: begin
`ifdef INC_AUTO_REPEAT_EN
                if (!sync) begin
                    state_nxt = DEB_RELEASE;
                end else if (tmr == RATE_LAST) begin
                    inc_nxt    = 1'b1;
                    tmr_reload = 1'b1;
                end
`else
                // Unreachable without auto-repeat; recover to a known state
                state_nxt = IDLE;
`endif
            end
            DEB_RELEASE: begin
                if (sync) begin
                    state_nxt = HOLD_DELAY;
                end else if (tmr == DEB_LAST) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Debounced level is high from accepted press until accepted release
    assign btn_level = (state == HOLD_DELAY) || (state == HOLD_REPEAT) || (state == DEB_RELEASE);

`ifdef INC_AUTO_REPEAT_EN
    assign repeating = (state == HOLD_REPEAT);
`else
    assign repeating = 1'b0;
`endif

endmodule

// File: tb/tb_inc_pulse_gen.sv
// Bench for inc_pulse_gen: directed press/bounce/glitch/reset scenarios plus
// randomized button activity, compared cycle by cycle against a run-length model.
module tb_inc_pulse_gen;

    localparam int DEB  = 4;
    localparam int DLY  = 8;
    localparam int RATE = 4;

    logic clk;
    logic reset;
    logic btn_in;
    logic inc;
    logic btn_level;
    logic repeating;

    int n_cmp;
    int n_err;
    bit sb_on;

    logic [2:0] exp_q[$];
    logic [2:0] exp_v;
    logic       prev_inc;

    inc_pulse_gen #(
        .DEB_CYCLES   (DEB),
        .REPEAT_DELAY (DLY),
        .REPEAT_RATE  (RATE),
        .CNT_W        (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_in    (btn_in),
        .inc       (inc),
        .btn_level (btn_level),
        .repeating (repeating)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: debounced level follows runs of DEB+1 equal synchronised samples;
    // while held, pulses come DLY cycles after a (re)start, then every RATE cycles.
    bit m_b0, m_b1, m_sy, m_lvl, m_started, m_pulse;
    int m_run1, m_run0, m_since;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_b0 = 0; m_b1 = 0; m_lvl = 0; m_started = 0;
            m_run1 = 0; m_run0 = 0; m_since = 0;
            exp_q.delete();
        end else begin
            m_sy = m_b1;
            m_b1 = m_b0;
            m_b0 = btn_in;
            m_pulse = 0;
            if (!m_lvl) begin
                if (m_sy) begin
                    m_run1++;
                    if (m_run1 == DEB + 1) begin
                        m_pulse = 1; m_lvl = 1; m_run0 = 0; m_since = 0; m_started = 0;
                    end
                end else begin
                    m_run1 = 0;
                end
            end else begin
                if (!m_sy) begin
                    m_run0++;
                    m_started = 0;
                    if (m_run0 == DEB + 1) begin
                        m_lvl = 0; m_run0 = 0; m_run1 = 0;
                    end
                end else if (m_run0 > 0) begin
                    m_run0 = 0; m_since = 0; m_started = 0;
                end else begin
`ifdef INC_AUTO_REPEAT_EN
                    m_since++;
                    if ((!m_started && m_since == DLY) || (m_started && m_since == RATE)) begin
                        m_pulse = 1; m_started = 1; m_since = 0;
                    end
`endif
                end
            end
            exp_q.push_back({m_pulse, m_lvl, m_lvl && (m_run0 == 0) && m_started});
        end
    end

    // scoreboard: compare outputs on the falling edge
    always @(negedge clk) begin
        if (sb_on) begin
            if (reset || exp_q.size() == 0) exp_v = 3'b000;
            else                            exp_v = exp_q.pop_front();
            check_val("outs{inc,lvl,rep}", {29'd0, inc, btn_level, repeating}, {29'd0, exp_v});
            check_val("inc_twice", {31'd0, inc & prev_inc}, 32'd0);
            prev_inc = inc;
        end
    end

    // hold btn_in at v for n cycles (called at a falling edge)
    task automatic drive(input logic v, input int n);
        btn_in = v;
        repeat (n) @(negedge clk);
    endtask

    // btn_in just went high from a quiet idle: count edges after the sampling edge to inc
    task automatic measure_latency(input string tag);
        int cnt;
        bit seen;
        cnt  = 0;
        seen = 0;
        @(posedge clk);
        while (!seen && cnt < 200) begin
            @(posedge clk);
            cnt++;
            #1;
            if (inc) seen = 1;
        end
        check_val(tag, cnt, DEB + 2);
    endtask

    initial begin
        logic v;
        int   n;
        n_cmp = 0; n_err = 0; prev_inc = 0;
        reset = 1'b1; btn_in = 1'b0; sb_on = 1'b1;
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        drive(0, 5);

        // clean press
        btn_in = 1'b1;
        measure_latency("lat_clean");
        @(negedge clk);
        drive(1, 20);
        drive(0, 12);

        // bounce 1,0,1,1,0 then hold
        drive(1, 1); drive(0, 1); drive(1, 2); drive(0, 1);
        btn_in = 1'b1;
        measure_latency("lat_bounce");
        @(negedge clk);
        drive(1, 10);
        drive(0, 12);

        // long hold with a short release glitch
        drive(1, 30);
        drive(0, 2);
        drive(1, 20);
        drive(0, 12);

        // fresh press after full release
        btn_in = 1'b1;
        measure_latency("lat_repress");
        @(negedge clk);
        drive(1, 25);

        // reset in the middle of a hold
`ifdef INC_AUTO_REPEAT_EN
        for (int i = 0; i < 20 && !inc; i++) begin
            @(posedge clk);
            #1;
        end
        check_val("pre_rst_inc", {31'd0, inc}, 32'd1);
        check_val("pre_rst_rep", {31'd0, repeating}, 32'd1);
`else
        @(posedge clk);
        #1;
`endif
        check_val("pre_rst_lvl", {31'd0, btn_level}, 32'd1);
        #1 reset = 1'b1;
        #1;
        check_val("rst_inc", {31'd0, inc}, 32'd0);
        check_val("rst_lvl", {31'd0, btn_level}, 32'd0);
        check_val("rst_rep", {31'd0, repeating}, 32'd0);
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;
        measure_latency("lat_after_rst");
        @(negedge clk);
        drive(1, 5);
        drive(0, 12);

        // random button activity
        v = 1'b0;
        for (int k = 0; k < 120; k++) begin
            v = ($urandom_range(0, 4) == 0) ? v : ~v;
            n = ($urandom_range(0, 3) == 0) ? $urandom_range(15, 40) : $urandom_range(1, 8);
            drive(v, n);
        end
        drive(0, 20);

        sb_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
